// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for the shift arbiter.
// Holds the shift operation encoding used on every requester's opcode lane
// and the width of that lane.
package shift_arbiter_pkg;

  localparam int SFT_OP_WIDTH = 2;

  // Opcode values are fixed because requesters drive them as raw bits.
  typedef enum logic [SFT_OP_WIDTH-1:0] {
    SRL = 2'd0,
    SRA = 2'd1,
    SLL = 2'd2,
    ROR = 2'd3
  } SFT_OP_E;

endpackage

// File: rtl/shift_unit.sv
// Combinational barrel shifter shared by all requesters.
// Ports:
//   op_i     - operation (SRL, SRA, SLL, ROR)
//   dat_i    - operand
//   amt_i    - shift amount, 0 to DATA_WIDTH-1
//   result_o - shifted operand, truncated to DATA_WIDTH
module shift_unit
  import shift_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int SHIFT_BIT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  SFT_OP_E                    op_i,
  input  logic [DATA_WIDTH-1:0]      dat_i,
  input  logic [SHIFT_BIT_WIDTH-1:0] amt_i,
  output logic [DATA_WIDTH-1:0]      result_o
);

  logic [2*DATA_WIDTH-1:0] rotDouble;

  // Rotating the operand concatenated with itself keeps amt_i == 0 well
  // defined, unlike combining a right shift with a left shift by
  // DATA_WIDTH-amt.
  always_comb begin
    rotDouble = {dat_i, dat_i} >> amt_i;
    result_o  = '0;
    unique case (op_i)
      SRL:     result_o = dat_i >> amt_i;
      SRA:     result_o = $signed(dat_i) >>> amt_i;
      SLL:     result_o = dat_i << amt_i;
      ROR:     result_o = rotDouble[DATA_WIDTH-1:0];
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter that lets REQ_NUM requesters share one shifter, with a
// single registered result stage on the output.
// Ports:
//   clk, rst    - clock and asynchronous active-high reset
//   iReqVld     - per-requester request valid
//   iReqOp      - per-requester opcode (SFT_OP_E), packed 2 bits per requester
//   iReqDat     - per-requester operand, packed DATA_WIDTH bits per requester
//   iReqSftBit  - per-requester shift amount, packed SHIFT_BIT_WIDTH bits each
//   oReqRdy     - one-hot accept to the winning requester (or all zeros)
//   oRsltVld    - result register holds a valid result
//   oRsltId     - index of the requester that owns the result
//   oRsltDat    - shift result
//   iRsltRdy    - downstream accepts the result
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int REQ_NUM         = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int SHIFT_BIT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [REQ_NUM-1:0]                 iReqVld,
  input  logic [REQ_NUM*SFT_OP_WIDTH-1:0]    iReqOp,
  input  logic [REQ_NUM*DATA_WIDTH-1:0]      iReqDat,
  input  logic [REQ_NUM*SHIFT_BIT_WIDTH-1:0] iReqSftBit,
  output logic [REQ_NUM-1:0]                 oReqRdy,
  output logic                               oRsltVld,
  output logic [$clog2(REQ_NUM)-1:0]         oRsltId,
  output logic [DATA_WIDTH-1:0]              oRsltDat,
  input  logic                               iRsltRdy
);

  localparam int ID_W = $clog2(REQ_NUM);

  // Parameter sanity checks at elaboration time.
  if (((DATA_WIDTH & (DATA_WIDTH - 1)) != 0) || (DATA_WIDTH < 8)) begin : gDataWidthErr
`ifdef CHECK_ERR_EXIT
    $fatal(1, "shift_arbiter: DATA_WIDTH %0d must be a power of two >= 8", DATA_WIDTH);
`else
    $error("shift_arbiter: DATA_WIDTH %0d must be a power of two >= 8", DATA_WIDTH);
`endif
  end
  if ((REQ_NUM < 2) || (REQ_NUM > 16)) begin : gReqNumErr
`ifdef CHECK_ERR_EXIT
    $fatal(1, "shift_arbiter: REQ_NUM %0d must be within 2 to 16", REQ_NUM);
`else
    $error("shift_arbiter: REQ_NUM %0d must be within 2 to 16", REQ_NUM);
`endif
  end
  if (SHIFT_BIT_WIDTH != $clog2(DATA_WIDTH)) begin : gSftWidthErr
`ifdef CHECK_ERR_EXIT
    $fatal(1, "shift_arbiter: SHIFT_BIT_WIDTH must equal clog2(DATA_WIDTH)");
`else
    $error("shift_arbiter: SHIFT_BIT_WIDTH must equal clog2(DATA_WIDTH)");
`endif
  end

  logic                       rsltVld_q, rsltVld_d;
  logic [ID_W-1:0]            rsltId_q, rsltId_d;
  logic [DATA_WIDTH-1:0]      rsltDat_q, rsltDat_d;
  logic [ID_W-1:0]            rrPtr_q, rrPtr_d;

  logic                       advance;
  logic                       anyVld;
  logic                       transfer;
  logic [ID_W-1:0]            winId;
  int                         cand;
  SFT_OP_E                    selOp;
  logic [DATA_WIDTH-1:0]      selDat;
  logic [SHIFT_BIT_WIDTH-1:0] selAmt;
  logic [DATA_WIDTH-1:0]      shiftRes;

  // The result stage can take a new entry when it is empty or being drained.
  assign advance = ~rsltVld_q | iRsltRdy;

  // Round-robin search: the first valid requester at or after rrPtr wins,
  // wrapping from REQ_NUM-1 back to 0.
  always_comb begin
    anyVld = 1'b0;
    winId  = '0;
    cand   = 0;
    for (int i = 0; i < REQ_NUM; i++) begin
      cand = int'(rrPtr_q) + i;
      if (cand >= REQ_NUM) begin
        cand = cand - REQ_NUM;
      end
      if (!anyVld && iReqVld[cand]) begin
        anyVld = 1'b1;
        winId  = ID_W'(cand);
      end
    end
  end

  // Reset is folded into the grant so no accept is signalled while it is held.
  assign transfer = anyVld & advance & ~rst;

  always_comb begin
    oReqRdy = '0;
    if (transfer) begin
      oReqRdy[winId] = 1'b1;
    end
  end

  // Only the winner's payload reaches the shifter.
  assign selOp  = SFT_OP_E'(iReqOp[winId*SFT_OP_WIDTH +: SFT_OP_WIDTH]);
  assign selDat = iReqDat[winId*DATA_WIDTH +: DATA_WIDTH];
  assign selAmt = iReqSftBit[winId*SHIFT_BIT_WIDTH +: SHIFT_BIT_WIDTH];

  shift_unit #(
    .DATA_WIDTH      (DATA_WIDTH),
    .SHIFT_BIT_WIDTH (SHIFT_BIT_WIDTH)
  ) uShiftUnit (
    .op_i     (selOp),
    .dat_i    (selDat),
    .amt_i    (selAmt),
    .result_o (shiftRes)
  );

  // A transfer overwrites the result stage even while it is draining, so
  // back-to-back results leave no bubble. Draining without a transfer only
  // clears the valid; the pointer moves solely on transfers.
  always_comb begin
    rsltVld_d = rsltVld_q;
    rsltId_d  = rsltId_q;
    rsltDat_d = rsltDat_q;
    rrPtr_d   = rrPtr_q;
    if (transfer) begin
      rsltVld_d = 1'b1;
      rsltId_d  = winId;
      rsltDat_d = shiftRes;
      if (winId == ID_W'(REQ_NUM - 1)) begin
        rrPtr_d = '0;
      end else begin
        rrPtr_d = winId + ID_W'(1);
      end
    end else if (advance) begin
      rsltVld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsltVld_q <= 1'b0;
      rsltId_q  <= '0;
      rsltDat_q <= '0;
      rrPtr_q   <= '0;
    end else begin
      rsltVld_q <= rsltVld_d;
      rsltId_q  <= rsltId_d;
      rsltDat_q <= rsltDat_d;
      rrPtr_q   <= rrPtr_d;
    end
  end

  assign oRsltVld = rsltVld_q;
  assign oRsltId  = rsltId_q;
  assign oRsltDat = rsltDat_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed testbench for shift_arbiter with 4 requesters and 32-bit data.
module tb_shift_arbiter;
  import shift_arbiter_pkg::*;

  localparam int REQ_NUM = 4;
  localparam int DW      = 32;
  localparam int SBW     = 5;

  logic                   clk;
  logic                   rst;
  logic [REQ_NUM-1:0]     iReqVld;
  logic [REQ_NUM*2-1:0]   iReqOp;
  logic [REQ_NUM*DW-1:0]  iReqDat;
  logic [REQ_NUM*SBW-1:0] iReqSftBit;
  logic [REQ_NUM-1:0]     oReqRdy;
  logic                   oRsltVld;
  logic [1:0]             oRsltId;
  logic [DW-1:0]          oRsltDat;
  logic                   iRsltRdy;

  int checks = 0;
  int errors = 0;

  shift_arbiter #(
    .REQ_NUM    (REQ_NUM),
    .DATA_WIDTH (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .iReqVld    (iReqVld),
    .iReqOp     (iReqOp),
    .iReqDat    (iReqDat),
    .iReqSftBit (iReqSftBit),
    .oReqRdy    (oReqRdy),
    .oRsltVld   (oRsltVld),
    .oRsltId    (oRsltId),
    .oRsltDat   (oRsltDat),
    .iRsltRdy   (iRsltRdy)
  );

  // 10 ns clock; rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it when the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one requester's valid and payload lanes.
  task automatic applyStimulus(input int idx, input logic vld, input logic [1:0] op,
                               input logic [DW-1:0] dat, input logic [SBW-1:0] amt);
    iReqVld[idx]              = vld;
    iReqOp[idx*2 +: 2]        = op;
    iReqDat[idx*DW +: DW]     = dat;
    iReqSftBit[idx*SBW +: SBW] = amt;
  endtask

  // Presents a single request, called just after a rising edge. Checks the
  // grant mid-cycle and the registered result one edge later.
  task automatic issueOne(input string tag, input int idx, input logic [1:0] op,
                          input logic [DW-1:0] dat, input logic [SBW-1:0] amt,
                          input logic [DW-1:0] expDat);
    iReqVld = '0;
    applyStimulus(idx, 1'b1, op, dat, amt);
    #3;
    checkOutput({tag, "_rdy"}, 64'(oReqRdy), 64'(4'b0001 << idx));
    @(posedge clk); #1;
    checkOutput({tag, "_vld"}, 64'(oRsltVld), 64'd1);
    checkOutput({tag, "_id"},  64'(oRsltId),  64'(idx));
    checkOutput({tag, "_dat"}, 64'(oRsltDat), 64'(expDat));
  endtask

  int expId;
  logic [DW-1:0] expDat4 [4];

  initial begin
    rst        = 1'b1;
    iReqVld    = '0;
    iReqOp     = '0;
    iReqDat    = '0;
    iReqSftBit = '0;
    iRsltRdy   = 1'b1;
    expDat4[0] = 32'd1;
    expDat4[1] = 32'd4;
    expDat4[2] = 32'd12;
    expDat4[3] = 32'd32;

    // Reset values, with a request present to show no grant under reset.
    applyStimulus(0, 1'b1, SRA, 32'h8000_0010, 5'd4);
    #2;
    checkOutput("rst_vld", 64'(oRsltVld), 64'd0);
    checkOutput("rst_id",  64'(oRsltId),  64'd0);
    checkOutput("rst_dat", 64'(oRsltDat), 64'd0);
    checkOutput("rst_rdy", 64'(oReqRdy),  64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single-requester operations; pointer walks 0->1->2->3->0->1->0.
    issueOne("sra4",   0, SRA, 32'h8000_0010, 5'd4,  32'hF800_0001);
    issueOne("ror4",   1, ROR, 32'h0000_00F1, 5'd4,  32'h1000_000F);
    issueOne("sll31",  2, SLL, 32'h0000_0001, 5'd31, 32'h8000_0000);
    issueOne("srl0",   3, SRL, 32'hFFFF_FFFF, 5'd0,  32'hFFFF_FFFF);
    issueOne("sra0",   0, SRA, 32'h8000_0010, 5'd0,  32'h8000_0010);
    issueOne("sra31",  3, SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);

    // No request: the pending result drains.
    iReqVld = '0;
    #3;
    checkOutput("idle_rdy", 64'(oReqRdy), 64'd0);
    @(posedge clk); #1;
    checkOutput("drain_vld", 64'(oRsltVld), 64'd0);

    // All four requesters valid: grants rotate 0,1,2,3,0 with no bubble.
    for (int k = 0; k < REQ_NUM; k++) begin
      applyStimulus(k, 1'b1, SLL, DW'(k + 1), SBW'(k));
    end
    for (int c = 0; c < 5; c++) begin
      expId = c % REQ_NUM;
      #3;
      checkOutput($sformatf("rr%0d_rdy", c), 64'(oReqRdy), 64'(4'b0001 << expId));
      @(posedge clk); #1;
      checkOutput($sformatf("rr%0d_vld", c), 64'(oRsltVld), 64'd1);
      checkOutput($sformatf("rr%0d_id", c),  64'(oRsltId),  64'(expId));
      checkOutput($sformatf("rr%0d_dat", c), 64'(oRsltDat), 64'(expDat4[expId]));
    end

    // Stall for 3 cycles holding requester 0's result.
    iRsltRdy = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #3;
      checkOutput($sformatf("stall%0d_rdy", s), 64'(oReqRdy), 64'd0);
      @(posedge clk); #1;
      checkOutput($sformatf("stall%0d_vld", s), 64'(oRsltVld), 64'd1);
      checkOutput($sformatf("stall%0d_id", s),  64'(oRsltId),  64'd0);
      checkOutput($sformatf("stall%0d_dat", s), 64'(oRsltDat), 64'd1);
    end
    iRsltRdy = 1'b1;
    #3;
    checkOutput("release_rdy", 64'(oReqRdy), 64'b0010);
    @(posedge clk); #1;
    checkOutput("release_id",  64'(oRsltId),  64'd1);
    checkOutput("release_dat", 64'(oRsltDat), 64'd4);

    // Drain, then leave the pointer at 3 by serving requester 2.
    iReqVld = '0;
    @(posedge clk); #1;
    checkOutput("drain2_vld", 64'(oRsltVld), 64'd0);
    issueOne("srl8", 2, SRL, 32'h0000_0100, 5'd8, 32'h0000_0001);

    // Asynchronous reset mid-cycle while a result is held.
    iReqVld  = '0;
    iRsltRdy = 1'b0;
    applyStimulus(2, 1'b1, SRL, 32'h0000_0100, 5'd8);
    applyStimulus(3, 1'b1, ROR, 32'h0000_0001, 5'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_vld", 64'(oRsltVld), 64'd0);
    checkOutput("arst_id",  64'(oRsltId),  64'd0);
    checkOutput("arst_dat", 64'(oRsltDat), 64'd0);
    checkOutput("arst_rdy", 64'(oReqRdy),  64'd0);
    @(negedge clk);
    rst      = 1'b0;
    iRsltRdy = 1'b1;
    #2;
    checkOutput("post_rst_rdy", 64'(oReqRdy), 64'b0100);
    @(posedge clk); #1;
    checkOutput("post_rst_id",  64'(oRsltId),  64'd2);
    checkOutput("post_rst_dat", 64'(oRsltDat), 64'h0000_0001);
    #3;
    checkOutput("next_rdy", 64'(oReqRdy), 64'b1000);
    @(posedge clk); #1;
    checkOutput("next_id",  64'(oRsltId),  64'd3);
    checkOutput("next_dat", 64'(oRsltDat), 64'h8000_0000);

    iReqVld = '0;
    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
